// File: rtl/cache_repl_pkg.sv
// Shared definitions for the 8-way / 128-set replacement controller:
// geometry, sequencer state encoding and one-hot helpers.
package cache_repl_pkg;

  localparam int WAYS  = 8;
  localparam int IDX_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TAG    = 3'd1,
    ST_CMP    = 3'd2,
    ST_REFILL = 3'd3,
    ST_UPD    = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  // Isolate the lowest set bit; returns zero when no bit is set.
  function automatic logic [WAYS-1:0] lowest_set(input logic [WAYS-1:0] v);
    return v & (~v + 1'b1);
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [WAYS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/way_select.sv
// Combinational way selection: tag compare across all ways, lowest-index
// priority on hits, and victim choice on a miss.
module way_select
  import cache_repl_pkg::*;
#(
  parameter int TAG_W = 19
) (
  input  logic [TAG_W-1:0]      tag,
  input  logic [WAYS*TAG_W-1:0] tag_data,
  input  logic [WAYS-1:0]       tag_valid,
  input  logic [WAYS-1:0]       lru_flag,
  output logic                  hit,
  output logic [WAYS-1:0]       hit_way,
  output logic [WAYS-1:0]       victim_way,
  output logic                  victim_is_lru
);

  logic [WAYS-1:0] hit_vec;

  // Per-way match, only counted when the way holds a valid line.
  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = tag_valid[w] && (tag_data[w*TAG_W +: TAG_W] == tag);
    end
  end

  // Duplicate matches resolve to the lowest way; empty ways are filled before
  // evicting, and a corrupt LRU flag falls back to way0.
  always_comb begin
    hit     = |hit_vec;
    hit_way = lowest_set(hit_vec);
    if (tag_valid != '1) begin
      victim_way = lowest_set(~tag_valid);
    end else if (is_onehot(lru_flag)) begin
      victim_way = lru_flag;
    end else begin
      victim_way = {{(WAYS-1){1'b0}}, 1'b1};
    end
    victim_is_lru = (victim_way == lru_flag);
  end

endmodule

// File: rtl/lru_repl_ctrl.sv
// Per-request sequencer for the cache replacement path: tag lookup, hit/miss
// decision, refill handshake, a single LRU update strobe and the response.
module lru_repl_ctrl
  import cache_repl_pkg::*;
#(
  parameter int ADDR_W = 26
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [ADDR_W-1:0]         i_req_addr,
  output logic [IDX_W-1:0]          o_tag_rd_index,
  input  logic [WAYS*(ADDR_W-IDX_W)-1:0] i_tag_rd_data,
  input  logic [WAYS-1:0]           i_tag_valid,
  output logic [IDX_W-1:0]          o_lru_addr_7,
  input  logic [WAYS-1:0]           i_lru_flag_8,
  output logic                      o_lru_we,
  output logic                      o_lru_hit_sig,
  output logic [WAYS-1:0]           o_lru_hit_way_8,
  output logic                      o_refill_req,
  output logic [ADDR_W-1:0]         o_refill_addr,
  input  logic                      i_refill_ack,
  output logic                      o_tag_wr_en,
  output logic [WAYS-1:0]           o_tag_wr_way_8,
  output logic [ADDR_W-IDX_W-1:0]   o_tag_wr_data,
  output logic                      o_resp_valid,
  input  logic                      i_resp_ready,
  output logic                      o_resp_hit,
  output logic [WAYS-1:0]           o_resp_way_8
);

  localparam int TAG_W = ADDR_W - IDX_W;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [WAYS-1:0]   way_q;
  logic              hit_q;
  logic              lru_sig_q;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;

  logic              cmp_hit;
  logic [WAYS-1:0]   cmp_hit_way;
  logic [WAYS-1:0]   cmp_victim;
  logic              cmp_victim_lru;

  assign tag_q = addr_q[ADDR_W-1:IDX_W];
  assign idx_q = addr_q[IDX_W-1:0];

  way_select #(.TAG_W(TAG_W)) u_way_select (
    .tag           (tag_q),
    .tag_data      (i_tag_rd_data),
    .tag_valid     (i_tag_valid),
    .lru_flag      (i_lru_flag_8),
    .hit           (cmp_hit),
    .hit_way       (cmp_hit_way),
    .victim_way    (cmp_victim),
    .victim_is_lru (cmp_victim_lru)
  );

  // State register; async reset also kills an in-flight refill request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Sequencing: one request in flight, new requests only taken in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (i_req_valid) state_nxt = ST_TAG;
      ST_TAG:    state_nxt = ST_CMP;
      ST_CMP:    state_nxt = cmp_hit ? ST_UPD : ST_REFILL;
      ST_REFILL: if (i_refill_ack) state_nxt = ST_UPD;
      ST_UPD:    state_nxt = ST_RESP;
      ST_RESP:   if (i_resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request address captured on accept; way and update style decided in CMP,
  // where the synchronous tag read data has arrived.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      way_q     <= '0;
      hit_q     <= 1'b0;
      lru_sig_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && i_req_valid) addr_q <= i_req_addr;
      if (state == ST_CMP) begin
        hit_q     <= cmp_hit;
        way_q     <= cmp_hit ? cmp_hit_way : cmp_victim;
        lru_sig_q <= cmp_hit | ~cmp_victim_lru;
      end
    end
  end

  // Outputs decoded from state and the captured request.
  always_comb begin
    o_req_ready     = 1'b0;
    o_tag_rd_index  = '0;
    o_lru_addr_7    = idx_q;
    o_lru_we        = 1'b0;
    o_lru_hit_sig   = 1'b0;
    o_lru_hit_way_8 = '0;
    o_refill_req    = 1'b0;
    o_refill_addr   = '0;
    o_tag_wr_en     = 1'b0;
    o_tag_wr_way_8  = '0;
    o_tag_wr_data   = '0;
    o_resp_valid    = 1'b0;
    o_resp_hit      = 1'b0;
    o_resp_way_8    = '0;
    case (state)
      ST_IDLE: o_req_ready = 1'b1;
      ST_TAG, ST_CMP: o_tag_rd_index = idx_q;
      ST_REFILL: begin
        o_tag_rd_index = idx_q;
        o_refill_req   = 1'b1;
        o_refill_addr  = addr_q;
      end
      ST_UPD: begin
        o_tag_rd_index  = idx_q;
        o_lru_we        = 1'b1;
        o_lru_hit_sig   = lru_sig_q;
        o_lru_hit_way_8 = lru_sig_q ? way_q : '0;
        o_tag_wr_en     = ~hit_q;
        o_tag_wr_way_8  = hit_q ? '0 : way_q;
        o_tag_wr_data   = hit_q ? '0 : tag_q;
      end
      ST_RESP: begin
        o_tag_rd_index = idx_q;
        o_resp_valid   = 1'b1;
        o_resp_hit     = hit_q;
        o_resp_way_8   = way_q;
      end
      default: ;
    endcase
  end

endmodule
